// File: rtl/adder_pkg.sv
// Shared defaults and derived sizing for the pipelined adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational ripple-carry segment built from XOR/AOI full-adder cells.
module rca_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           Cin,
  output logic [SEG-1:0] sum,
  output logic           Cout
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < SEG; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign Cout = c[SEG];

endmodule

// File: rtl/pipe_adder.sv
// Valid/ready pipelined add/subtract: one ripple segment per stage, carries
// and skewed operand/sum bits registered at each stage boundary.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             of
);

  localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned MID  = (STAGES > 1) ? STAGES - 1 : 1;

  logic              en;
  logic [STAGES-1:0] vld;

  // Inter-stage skew registers (operands, partial sum, boundary carry)
  logic [WIDTH-1:0] a_q [MID];
  logic [WIDTH-1:0] b_q [MID];
  logic [WIDTH-1:0] s_q [MID];
  logic             c_q [MID];

  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [SEG-1:0]   seg_sum [STAGES];
  logic             seg_c   [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];

  assign en        = !vld[LAST] || out_ready;
  assign in_ready  = !rst_n || en;
  assign out_valid = vld[LAST];

  // Stage inputs: raw prepared operands for stage 0, skew registers after
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        src_a[s] = a;
        src_b[s] = b ^ {WIDTH{sub}};
        src_s[s] = '0;
        src_c[s] = Cin ^ sub;
      end else begin
        src_a[s] = a_q[s-1];
        src_b[s] = b_q[s-1];
        src_s[s] = s_q[s-1];
        src_c[s] = c_q[s-1];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_seg
    rca_segment #(.SEG(SEG)) u_seg (
      .a    (src_a[s][s*SEG +: SEG]),
      .b    (src_b[s][s*SEG +: SEG]),
      .Cin  (src_c[s]),
      .sum  (seg_sum[s]),
      .Cout (seg_c[s])
    );
  end

  // Merge each stage's freshly computed segment into the travelling sum
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      nxt_s[s]                = src_s[s];
      nxt_s[s][s*SEG +: SEG]  = seg_sum[s];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= '0;
      sum  <= '0;
      Cout <= 1'b0;
      of   <= 1'b0;
      for (int unsigned s = 0; s < MID; s++) begin
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
        c_q[s] <= 1'b0;
      end
    end else if (en) begin
      vld[0] <= in_valid;
      for (int unsigned s = 1; s < STAGES; s++) begin
        vld[s] <= vld[s-1];
      end
      for (int unsigned s = 0; s < LAST; s++) begin
        a_q[s] <= src_a[s];
        b_q[s] <= src_b[s];
        s_q[s] <= nxt_s[s];
        c_q[s] <= seg_c[s];
      end
      sum  <= nxt_s[LAST];
      Cout <= seg_c[LAST];
      of   <= (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
              (nxt_s[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    end
  end

endmodule
